// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. After a start pulse it reads instruction memory
// sequentially from pc 0. It keeps at most one read outstanding and places each
// returned word, tagged with its address, into a 2-entry FIFO for the decoder.
// Fetching stops once a word whose opcode field equals HALT_OP has been fetched.
// A branch redirect from execute flushes the FIFO and restarts fetching at
// redir_pc. A read response that is still in flight when the redirect happens
// is recognised when it arrives and thrown away.
//
// Parameters
//   PC_W        instruction-address width
//   HALT_OP     opcode (inst[19:15]) that stops fetching
//
// Ports
//   clk         clock, all state on the rising edge
//   rst_n       synchronous active-low reset
//   start       one-cycle pulse, begins fetching at pc 0 (only honoured in IDLE)
//   imem_req    read request (combinational from state and queue occupancy)
//   imem_addr   read address (0 when no request)
//   imem_valid  read response strobe for the outstanding request
//   imem_rdata  read response data
//   redir       branch redirect from execute
//   redir_pc    redirect target
//   f_valid     queue head is valid
//   f_op        opcode of the queue head
//   f_inst      instruction word of the queue head
//   f_pc        address of the queue head
//   dec_ready   decoder consumes the queue head this cycle
//   done        halted, queue drained, no response pending to discard
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int         PC_W    = 15,
    parameter logic [4:0] HALT_OP = 5'd31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [19:0]     imem_rdata,
    input  logic            redir,
    input  logic [PC_W-1:0] redir_pc,
    output logic            f_valid,
    output logic [4:0]      f_op,
    output logic [19:0]     f_inst,
    output logic [PC_W-1:0] f_pc,
    input  logic            dec_ready,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic            r_drop;
    logic            w_drop_next;
    logic [1:0]      r_count;
    logic [1:0]      w_count_next;
    logic            r_head;
    logic            w_head_next;

    logic [19:0]     r_q_word [2];
    logic [PC_W-1:0] r_q_pc   [2];

    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_wr_idx;
    logic [19:0]     w_head_word;
    logic [PC_W-1:0] w_head_pc;

    // A request is only allowed when the response has somewhere to go and no
    // stale response from before a redirect is still on its way back.
    assign w_req    = (r_state == S_REQ) && (r_count != 2'd2) && !r_drop;
    assign w_pop    = (r_count != 2'd0) && dec_ready;
    // Tail slot. A push only happens while count <= 1, so one bit suffices.
    assign w_wr_idx = r_head ^ r_count[0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_drop_next  = r_drop;
        w_push       = 1'b0;
        w_flush      = 1'b0;

        if ((r_state != S_IDLE) && redir) begin
            // Redirect wins over everything, including a response arriving in
            // the same cycle (that response belongs to the wrong path).
            w_state_next = S_REQ;
            w_pc_next    = redir_pc;
            w_flush      = 1'b1;
            // Remember to discard a response that is still in flight. An
            // already-pending discard stays pending unless it lands now.
            w_drop_next  = !imem_valid && ((r_state == S_WAIT) || r_drop);
        end else if (r_drop && imem_valid) begin
            // Stale response from before the redirect: swallow it, pc unchanged.
            w_drop_next = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = S_REQ;
                        w_pc_next    = '0;
                    end
                end
                S_REQ: begin
                    if (w_req) begin
                        w_state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        w_push       = 1'b1;
                        w_pc_next    = r_pc + 1'b1;  // wraps modulo 2^PC_W
                        w_state_next = (imem_rdata[19:15] == HALT_OP) ? S_HALTED : S_REQ;
                    end
                end
                S_HALTED: begin
                    w_state_next = S_HALTED;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Queue occupancy and head pointer. A flush empties the queue even when the
    // decoder pops in the same cycle; that popped entry still counts as taken.
    always_comb begin
        w_count_next = r_count;
        w_head_next  = r_head;
        if (w_flush) begin
            w_count_next = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
        if (w_pop) begin
            w_head_next = ~r_head;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_drop  <= 1'b0;
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_drop  <= w_drop_next;
            r_count <= w_count_next;
            r_head  <= w_head_next;
        end
    end

    // Queue storage: instruction word plus the address it was fetched from.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_q_word[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_q_word[w_wr_idx] <= imem_rdata;
            r_q_pc[w_wr_idx]   <= r_pc;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign w_head_word = r_q_word[r_head];
    assign w_head_pc   = r_q_pc[r_head];

    assign imem_req  = w_req;
    assign imem_addr = w_req ? r_pc : '0;

    // Head fields are forced to zero while the queue is empty so the decoder
    // never sees a stale, already-consumed entry.
    assign f_valid = (r_count != 2'd0);
    assign f_inst  = f_valid ? w_head_word : 20'd0;
    assign f_op    = f_inst[19:15];
    assign f_pc    = f_valid ? w_head_pc : '0;

    assign done = (r_state == S_HALTED) && (r_count == 2'd0) && !r_drop;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A memory model answers the DUT's read requests with a
// configurable latency. A queue-based reference model of the fetch rules runs
// alongside; directed scenarios check fixed expected values and a randomized
// run compares every DUT output against the reference model each cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W     = 15;
    localparam int S_IDLE   = 0;
    localparam int S_REQ    = 1;
    localparam int S_WAIT   = 2;
    localparam int S_HALTED = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [19:0]     imem_rdata;
    logic            redir;
    logic [PC_W-1:0] redir_pc;
    logic            f_valid;
    logic [4:0]      f_op;
    logic [19:0]     f_inst;
    logic [PC_W-1:0] f_pc;
    logic            dec_ready;
    logic            done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    typedef struct packed {
        logic [19:0]     word;
        logic [PC_W-1:0] pc;
    } entry_t;
    entry_t          m_q[$];
    int              m_state;
    logic [PC_W-1:0] m_pc;
    bit              m_drop;

    // Memory model state
    logic [19:0]     mem [0:32767];
    bit              pend;
    logic [PC_W-1:0] pend_addr;
    int              pend_wait;
    int              lat_cfg;   // 0 = random latency 1..4

    fetch_unit #(.PC_W(PC_W), .HALT_OP(5'd31)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .redir      (redir),
        .redir_pc   (redir_pc),
        .f_valid    (f_valid),
        .f_op       (f_op),
        .f_inst     (f_inst),
        .f_pc       (f_pc),
        .dec_ready  (dec_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Random program; about one word in halt_one_in carries the halt opcode.
    task automatic fill_mem(input int halt_one_in);
        logic [19:0] w;
        for (int a = 0; a < 32768; a++) begin
            w = 20'($urandom);
            if (halt_one_in > 0 && $urandom_range(1, halt_one_in) == 1) w[19:15] = 5'd31;
            else if (w[19:15] == 5'd31) w[19:15] = 5'd30;
            mem[a] = w;
        end
    endtask

    // Reference model: one clock of the fetch rules applied to current inputs.
    task automatic model_step();
        bit req_now;
        req_now = (m_state == S_REQ) && (m_q.size() < 2) && !m_drop;
        if (!rst_n) begin
            m_state = S_IDLE;
            m_pc    = '0;
            m_drop  = 0;
            m_q.delete();
            return;
        end
        if (m_q.size() > 0 && dec_ready) void'(m_q.pop_front());
        if (m_state != S_IDLE && redir) begin
            m_q.delete();
            m_drop  = !imem_valid && (m_state == S_WAIT || m_drop);
            m_pc    = redir_pc;
            m_state = S_REQ;
        end else if (m_drop && imem_valid) begin
            m_drop = 0;
        end else if (m_state == S_IDLE) begin
            if (start) begin
                m_state = S_REQ;
                m_pc    = '0;
            end
        end else if (m_state == S_REQ) begin
            if (req_now) m_state = S_WAIT;
        end else if (m_state == S_WAIT) begin
            if (imem_valid) begin
                m_q.push_back('{word: imem_rdata, pc: m_pc});
                m_pc    = PC_W'((int'(m_pc) + 1) % (1 << PC_W));
                m_state = (imem_rdata[19:15] == 5'd31) ? S_HALTED : S_REQ;
            end
        end
    endtask

    // Advance one clock: update the model, let memory see any request, then
    // present the memory response for the next cycle.
    task automatic tick();
        model_step();
        if (imem_req) begin
            pend      = 1;
            pend_addr = imem_addr;
            pend_wait = ((lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg) - 1;
        end
        @(posedge clk);
        #1;
        if (pend && pend_wait == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[pend_addr];
            pend       = 0;
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 20'd0;
            if (pend) pend_wait--;
        end
    endtask

    // Reset long enough for any in-flight memory response to drain.
    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; redir = 1'b0; dec_ready = 1'b0; redir_pc = '0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem_req, imem_addr, f_valid, f_op, f_inst, f_pc, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%0d addr=%0h fv=%0d op=%0h inst=%0h pc=%0h done=%0d required all 0",
                     imem_req, imem_addr, f_valid, f_op, f_inst, f_pc, done);
        end
        // Redirect while idle must not start fetching.
        redir = 1'b1; redir_pc = 15'h0005;
        tick();
        redir = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0) begin
            failures++;
            $display("FAIL idle_redir_ignored got req=%0d addr=%0h required req=0 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_straight();
        int reqs[$];
        int pops_pc[$];
        int pops_op[$];
        int pops_inst[$];
        int last_pop;
        int done_at;
        bit overlap;
        last_pop = -1; done_at = -1; overlap = 0;
        do_reset();
        fill_mem(0);
        mem[0] = 20'h00001; mem[1] = 20'h08002; mem[2] = 20'hF8000; mem[3] = 20'h00003;
        lat_cfg = 1; dec_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            if (imem_req) reqs.push_back(int'(imem_addr));
            if (imem_valid && f_valid) overlap = 1;
            if (f_valid && dec_ready) begin
                pops_pc.push_back(int'(f_pc));
                pops_op.push_back(int'(f_op));
                pops_inst.push_back(int'(f_inst));
                last_pop = c;
            end
            if (done) done_at = c;
            tick();
        end
        checks++;
        if (reqs.size() != 3 || reqs[0] != 0 || reqs[1] != 1 || reqs[2] != 2) begin
            failures++;
            $display("FAIL straight_reqs got %0d requests (first addrs %p) required addrs 0,1,2 only", reqs.size(), reqs);
        end
        checks++;
        if (pops_pc.size() != 3 || pops_pc[0] != 0 || pops_pc[1] != 1 || pops_pc[2] != 2) begin
            failures++;
            $display("FAIL straight_fpc got %p required 0,1,2", pops_pc);
        end
        checks++;
        if (pops_op.size() != 3 || pops_op[0] != 0 || pops_op[1] != 1 || pops_op[2] != 31) begin
            failures++;
            $display("FAIL straight_fop got %p required 0,1,31", pops_op);
        end
        checks++;
        if (pops_inst.size() != 3 || pops_inst[1] != 'h08002 || pops_inst[2] != 'hF8000) begin
            failures++;
            $display("FAIL straight_finst got %p required 1,8002,f8000 (hex)", pops_inst);
        end
        checks++;
        if (last_pop < 0 || done_at != last_pop + 1) begin
            failures++;
            $display("FAIL straight_done got done at cycle %0d last pop %0d required last pop + 1", done_at, last_pop);
        end
        checks++;
        if (overlap) begin
            failures++;
            $display("FAIL straight_registered got f_valid=1 with imem_valid required f_valid=0 in response cycle");
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        int first_req;
        int pops[$];
        bit seq_ok;
        nreq = 0; first_req = -1;
        do_reset();
        fill_mem(0);
        lat_cfg = 1; dec_ready = 1'b0;
        pulse_start();
        for (int c = 0; c < 14; c++) begin
            if (imem_req) nreq++;
            tick();
        end
        checks++;
        if (nreq != 2) begin
            failures++;
            $display("FAIL bp_request_count got %0d required 2", nreq);
        end
        checks++;
        if (imem_req !== 1'b0 || f_valid !== 1'b1 || f_pc !== 15'd0) begin
            failures++;
            $display("FAIL bp_hold got req=%0d fv=%0d fpc=%0h required req=0 fv=1 fpc=0", imem_req, f_valid, f_pc);
        end
        dec_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (imem_req && first_req < 0) first_req = int'(imem_addr);
            if (f_valid && dec_ready) pops.push_back(int'(f_pc));
            tick();
        end
        checks++;
        if (first_req != 2) begin
            failures++;
            $display("FAIL bp_resume_addr got %0d required 2", first_req);
        end
        seq_ok = (pops.size() >= 5);
        foreach (pops[i]) if (pops[i] != i) seq_ok = 0;
        checks++;
        if (!seq_ok) begin
            failures++;
            $display("FAIL bp_order got %p required consecutive pcs from 0 (at least 5)", pops);
        end
    endtask

    task automatic test_redirect_wait();
        int g;
        int first_req, req_cyc, valid_cyc, first_fpc;
        bit saw_pc1;
        first_req = -1; req_cyc = -1; valid_cyc = -1; first_fpc = -1; saw_pc1 = 0;
        do_reset();
        fill_mem(0);
        lat_cfg = 3; dec_ready = 1'b1;
        pulse_start();
        for (g = 0; g < 30 && !(imem_req && imem_addr == 15'd1); g++) tick();
        checks++;
        if (g >= 30) begin
            failures++;
            $display("FAIL redir_wait_timeout got no request to pc 1 within 30 cycles required one");
        end
        tick();   // request to pc 1 issued
        redir = 1'b1; redir_pc = 15'h0100;
        tick();
        redir = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (imem_valid && valid_cyc < 0) valid_cyc = c;
            if (imem_req && first_req < 0) begin first_req = int'(imem_addr); req_cyc = c; end
            if (f_valid && first_fpc < 0) first_fpc = int'(f_pc);
            if (f_valid && f_pc == 15'd1) saw_pc1 = 1;
            tick();
        end
        checks++;
        if (first_req != 'h100) begin
            failures++;
            $display("FAIL redir_wait_addr got %0h required 100", first_req);
        end
        checks++;
        if (valid_cyc < 0 || req_cyc <= valid_cyc) begin
            failures++;
            $display("FAIL redir_wait_hold got request cycle %0d stale response cycle %0d required request after response", req_cyc, valid_cyc);
        end
        checks++;
        if (first_fpc != 'h100 || saw_pc1) begin
            failures++;
            $display("FAIL redir_wait_fpc got first %0h pc1_seen=%0d required 100 and no pc 1", first_fpc, saw_pc1);
        end
    endtask

    task automatic test_redir_valid();
        int g;
        do_reset();
        fill_mem(0);
        lat_cfg = 2; dec_ready = 1'b1;
        pulse_start();
        for (g = 0; g < 20 && !imem_valid; g++) tick();
        checks++;
        if (g >= 20) begin
            failures++;
            $display("FAIL rv_timeout got no response within 20 cycles required one");
        end
        redir = 1'b1; redir_pc = 15'h0ABC;
        tick();
        redir = 1'b0;
        checks++;
        if (f_valid !== 1'b0) begin
            failures++;
            $display("FAIL rv_fvalid got %0d required 0", f_valid);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 15'h0ABC) begin
            failures++;
            $display("FAIL rv_next_addr got req=%0d addr=%0h required req=1 addr=abc", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        int g;
        do_reset();
        fill_mem(0);
        lat_cfg = 1; dec_ready = 1'b0;
        pulse_start();
        for (g = 0; g < 20 && !imem_valid; g++) tick();
        redir = 1'b1; redir_pc = 15'h7FFF;
        tick();
        redir = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 15'h7FFF) begin
            failures++;
            $display("FAIL wrap_first got req=%0d addr=%0h required req=1 addr=7fff", imem_req, imem_addr);
        end
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin
            failures++;
            $display("FAIL wrap_addr got req=%0d addr=%0h required req=1 addr=0", imem_req, imem_addr);
        end
        checks++;
        if (f_valid !== 1'b1 || f_pc !== 15'h7FFF) begin
            failures++;
            $display("FAIL wrap_fpc got fv=%0d fpc=%0h required fv=1 fpc=7fff", f_valid, f_pc);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        bit bad;
        bad = 0;
        do_reset();
        fill_mem(0);
        lat_cfg = 3; dec_ready = 1'b0;
        pulse_start();
        for (g = 0; g < 30 && !(imem_req && imem_addr == 15'd1); g++) tick();
        tick();   // second request now outstanding, one entry queued
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({imem_req, imem_addr, f_valid, f_op, f_inst, f_pc, done} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got req=%0d addr=%0h fv=%0d op=%0h inst=%0h pc=%0h done=%0d required all 0",
                     imem_req, imem_addr, f_valid, f_op, f_inst, f_pc, done);
        end
        // The abandoned response lands while idle and must leave no trace.
        for (int c = 0; c < 5; c++) begin
            if (imem_req || f_valid || done) bad = 1;
            tick();
        end
        checks++;
        if (bad || f_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_late_valid got activity after reset required none");
        end
        pulse_start();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 15'd0) begin
            failures++;
            $display("FAIL midrst_restart got req=%0d addr=%0h required req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        bit              e_req, e_fv, e_done;
        logic [PC_W-1:0] e_addr, e_pc;
        logic [19:0]     e_inst;
        do_reset();
        fill_mem(12);
        lat_cfg = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_req  = (m_state == S_REQ) && (m_q.size() < 2) && !m_drop;
            e_addr = e_req ? m_pc : '0;
            e_fv   = (m_q.size() > 0);
            e_inst = e_fv ? m_q[0].word : 20'd0;
            e_pc   = e_fv ? m_q[0].pc : '0;
            e_done = (m_state == S_HALTED) && (m_q.size() == 0) && !m_drop;
            checks++;
            if (imem_req !== e_req) begin
                failures++;
                $display("FAIL rand_req cyc=%0d got %0d required %0d", cyc, imem_req, e_req);
            end
            checks++;
            if (imem_addr !== e_addr) begin
                failures++;
                $display("FAIL rand_addr cyc=%0d got %0h required %0h", cyc, imem_addr, e_addr);
            end
            checks++;
            if (f_valid !== e_fv) begin
                failures++;
                $display("FAIL rand_fvalid cyc=%0d got %0d required %0d", cyc, f_valid, e_fv);
            end
            checks++;
            if (f_inst !== e_inst) begin
                failures++;
                $display("FAIL rand_finst cyc=%0d got %0h required %0h", cyc, f_inst, e_inst);
            end
            checks++;
            if (f_op !== e_inst[19:15]) begin
                failures++;
                $display("FAIL rand_fop cyc=%0d got %0h required %0h", cyc, f_op, e_inst[19:15]);
            end
            checks++;
            if (f_pc !== e_pc) begin
                failures++;
                $display("FAIL rand_fpc cyc=%0d got %0h required %0h", cyc, f_pc, e_pc);
            end
            checks++;
            if (done !== e_done) begin
                failures++;
                $display("FAIL rand_done cyc=%0d got %0d required %0d", cyc, done, e_done);
            end
            rst_n     = ($urandom_range(0, 399) != 0);
            start     = ($urandom_range(0, 3) == 0) && (m_state != S_IDLE || !pend);
            dec_ready = ($urandom_range(0, 9) < 7);
            // Redirect only when no request is being issued and no stale
            // response is pending, so every response has one clear owner.
            redir     = !e_req && !m_drop && ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 3) == 0) redir_pc = 15'h7FFE + 15'($urandom_range(0, 1));
            else redir_pc = 15'($urandom);
            tick();
        end
        rst_n = 1'b1; start = 1'b0; redir = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; redir = 1'b0; redir_pc = '0; dec_ready = 1'b0;
        imem_valid = 1'b0; imem_rdata = 20'd0;
        m_state = S_IDLE; m_pc = '0; m_drop = 0;
        pend = 0; pend_addr = '0; pend_wait = 0; lat_cfg = 1;
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect_wait();
        test_redir_valid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
